// File: rtl/mt_fake_axi_arb.sv
// mt_fake_axi_arb: 2:1 AXI4 arbiter sharing one fake RAM between two masters; ID MSB tags the owner.
// Define MT_FAKE_AXI_ARB_FIXED_PRIO_EN for fixed master-0 priority instead of per-channel round robin.
`ifndef AXI4_ID_WIDTH
`define AXI4_ID_WIDTH 4
`endif
`ifndef AXI4_ADDR_WIDTH
`define AXI4_ADDR_WIDTH 64
`endif
`ifndef AXI4_DATA_WIDTH
`define AXI4_DATA_WIDTH 512
`endif
`ifndef AXI4_STRB_WIDTH
`define AXI4_STRB_WIDTH 64
`endif
module mt_fake_axi_arb #(
  parameter int ID_WIDTH   = `AXI4_ID_WIDTH,
  parameter int ADDR_WIDTH = `AXI4_ADDR_WIDTH,
  parameter int DATA_WIDTH = `AXI4_DATA_WIDTH,
  parameter int STRB_WIDTH = `AXI4_STRB_WIDTH
) (
  input  logic                  clk, rst,
  input  logic [ID_WIDTH-1:0]   s0_axi_awid, s1_axi_awid,
  input  logic [ADDR_WIDTH-1:0] s0_axi_awaddr, s1_axi_awaddr,
  input  logic [7:0]            s0_axi_awlen, s1_axi_awlen,
  input  logic [2:0]            s0_axi_awsize, s1_axi_awsize,
  input  logic [1:0]            s0_axi_awburst, s1_axi_awburst,
  input  logic                  s0_axi_awlock, s1_axi_awlock,
  input  logic [3:0]            s0_axi_awcache, s1_axi_awcache,
  input  logic [2:0]            s0_axi_awprot, s1_axi_awprot,
  input  logic                  s0_axi_awvalid, s1_axi_awvalid,
  output logic                  s0_axi_awready, s1_axi_awready,
  input  logic [DATA_WIDTH-1:0] s0_axi_wdata, s1_axi_wdata,
  input  logic [STRB_WIDTH-1:0] s0_axi_wstrb, s1_axi_wstrb,
  input  logic                  s0_axi_wlast, s1_axi_wlast, s0_axi_wvalid, s1_axi_wvalid,
  output logic                  s0_axi_wready, s1_axi_wready,
  output logic [ID_WIDTH-1:0]   s0_axi_bid, s1_axi_bid,
  output logic [1:0]            s0_axi_bresp, s1_axi_bresp,
  output logic                  s0_axi_bvalid, s1_axi_bvalid,
  input  logic                  s0_axi_bready, s1_axi_bready,
  input  logic [ID_WIDTH-1:0]   s0_axi_arid, s1_axi_arid,
  input  logic [ADDR_WIDTH-1:0] s0_axi_araddr, s1_axi_araddr,
  input  logic [7:0]            s0_axi_arlen, s1_axi_arlen,
  input  logic [2:0]            s0_axi_arsize, s1_axi_arsize,
  input  logic [1:0]            s0_axi_arburst, s1_axi_arburst,
  input  logic                  s0_axi_arlock, s1_axi_arlock,
  input  logic [3:0]            s0_axi_arcache, s1_axi_arcache,
  input  logic [2:0]            s0_axi_arprot, s1_axi_arprot,
  input  logic                  s0_axi_arvalid, s1_axi_arvalid,
  output logic                  s0_axi_arready, s1_axi_arready,
  output logic [ID_WIDTH-1:0]   s0_axi_rid, s1_axi_rid,
  output logic [DATA_WIDTH-1:0] s0_axi_rdata, s1_axi_rdata,
  output logic [1:0]            s0_axi_rresp, s1_axi_rresp,
  output logic                  s0_axi_rlast, s1_axi_rlast, s0_axi_rvalid, s1_axi_rvalid,
  input  logic                  s0_axi_rready, s1_axi_rready,
  output logic [ID_WIDTH:0]     m_axi_awid,
  output logic [ADDR_WIDTH-1:0] m_axi_awaddr,
  output logic [7:0]            m_axi_awlen,
  output logic [2:0]            m_axi_awsize,
  output logic [1:0]            m_axi_awburst,
  output logic                  m_axi_awlock,
  output logic [3:0]            m_axi_awcache,
  output logic [2:0]            m_axi_awprot,
  output logic                  m_axi_awvalid,
  input  logic                  m_axi_awready,
  output logic [DATA_WIDTH-1:0] m_axi_wdata,
  output logic [STRB_WIDTH-1:0] m_axi_wstrb,
  output logic                  m_axi_wlast, m_axi_wvalid,
  input  logic                  m_axi_wready,
  input  logic [ID_WIDTH:0]     m_axi_bid,
  input  logic [1:0]            m_axi_bresp,
  input  logic                  m_axi_bvalid,
  output logic                  m_axi_bready,
  output logic [ID_WIDTH:0]     m_axi_arid,
  output logic [ADDR_WIDTH-1:0] m_axi_araddr,
  output logic [7:0]            m_axi_arlen,
  output logic [2:0]            m_axi_arsize,
  output logic [1:0]            m_axi_arburst,
  output logic                  m_axi_arlock,
  output logic [3:0]            m_axi_arcache,
  output logic [2:0]            m_axi_arprot,
  output logic                  m_axi_arvalid,
  input  logic                  m_axi_arready,
  input  logic [ID_WIDTH:0]     m_axi_rid,
  input  logic [DATA_WIDTH-1:0] m_axi_rdata,
  input  logic [1:0]            m_axi_rresp,
  input  logic                  m_axi_rlast, m_axi_rvalid,
  output logic                  m_axi_rready
);
  logic ar_busy_q, ar_busy_d, ar_gnt_q, ar_gnt_d, ar_pick, ar_hs;
  logic aw_busy_q, aw_busy_d, aw_gnt_q, aw_gnt_d, aw_pick, aw_hs, wl_hs, aw_fin;
  logic aw_done_q, aw_done_d, w_done_q, w_done_d;
  logic r_sel, b_sel;
`ifdef MT_FAKE_AXI_ARB_FIXED_PRIO_EN
  assign ar_pick = ~s0_axi_arvalid;
  assign aw_pick = ~s0_axi_awvalid;
`else
  logic ar_ptr_q, ar_ptr_d, aw_ptr_q, aw_ptr_d;
  assign ar_pick = (s0_axi_arvalid & s1_axi_arvalid) ? ar_ptr_q : s1_axi_arvalid;
  assign aw_pick = (s0_axi_awvalid & s1_axi_awvalid) ? aw_ptr_q : s1_axi_awvalid;
  always_comb begin
    ar_ptr_d = (~ar_busy_q & (s0_axi_arvalid | s1_axi_arvalid)) ? ~ar_pick : ar_ptr_q;
    aw_ptr_d = (~aw_busy_q & (s0_axi_awvalid | s1_axi_awvalid)) ? ~aw_pick : aw_ptr_q;
  end
  always_ff @(posedge clk) begin
    ar_ptr_q <= rst ? 1'b0 : ar_ptr_d;
    aw_ptr_q <= rst ? 1'b0 : aw_ptr_d;
  end
`endif
  always_ff @(posedge clk) begin
    if (rst) begin
      ar_busy_q <= 1'b0;
      ar_gnt_q  <= 1'b0;
      aw_busy_q <= 1'b0;
      aw_gnt_q  <= 1'b0;
      aw_done_q <= 1'b0;
      w_done_q  <= 1'b0;
    end else begin
      ar_busy_q <= ar_busy_d;
      ar_gnt_q  <= ar_gnt_d;
      aw_busy_q <= aw_busy_d;
      aw_gnt_q  <= aw_gnt_d;
      aw_done_q <= aw_done_d;
      w_done_q  <= w_done_d;
    end
  end
  assign ar_hs  = m_axi_arvalid & m_axi_arready;
  assign aw_hs  = m_axi_awvalid & m_axi_awready;
  assign wl_hs  = m_axi_wvalid & m_axi_wready & m_axi_wlast;
  assign aw_fin = aw_busy_q & (aw_done_q | aw_hs) & (w_done_q | wl_hs);
  always_comb begin
    ar_busy_d = ar_busy_q ? ~ar_hs : (s0_axi_arvalid | s1_axi_arvalid);
    ar_gnt_d  = ar_busy_q ? ar_gnt_q : ar_pick;
    aw_busy_d = aw_busy_q ? ~aw_fin : (s0_axi_awvalid | s1_axi_awvalid);
    aw_gnt_d  = aw_busy_q ? aw_gnt_q : aw_pick;
    aw_done_d = aw_busy_q & ~aw_fin & (aw_done_q | aw_hs);
    w_done_d  = aw_busy_q & ~aw_fin & (w_done_q | wl_hs);
  end
  // every valid/ready is gated by rst so nothing leaks while reset is held
  always_comb begin
    r_sel          = m_axi_rid[ID_WIDTH];
    b_sel          = m_axi_bid[ID_WIDTH];
    m_axi_arvalid  = ~rst & ar_busy_q & (ar_gnt_q ? s1_axi_arvalid : s0_axi_arvalid);
    s0_axi_arready = ~rst & ar_busy_q & ~ar_gnt_q & m_axi_arready;
    s1_axi_arready = ~rst & ar_busy_q & ar_gnt_q & m_axi_arready;
    m_axi_awvalid  = ~rst & aw_busy_q & ~aw_done_q & (aw_gnt_q ? s1_axi_awvalid : s0_axi_awvalid);
    s0_axi_awready = ~rst & aw_busy_q & ~aw_done_q & ~aw_gnt_q & m_axi_awready;
    s1_axi_awready = ~rst & aw_busy_q & ~aw_done_q & aw_gnt_q & m_axi_awready;
    m_axi_wvalid   = ~rst & aw_busy_q & ~w_done_q & (aw_gnt_q ? s1_axi_wvalid : s0_axi_wvalid);
    s0_axi_wready  = ~rst & aw_busy_q & ~w_done_q & ~aw_gnt_q & m_axi_wready;
    s1_axi_wready  = ~rst & aw_busy_q & ~w_done_q & aw_gnt_q & m_axi_wready;
    s0_axi_rvalid  = ~rst & m_axi_rvalid & ~r_sel;
    s1_axi_rvalid  = ~rst & m_axi_rvalid & r_sel;
    m_axi_rready   = ~rst & (r_sel ? s1_axi_rready : s0_axi_rready);
    s0_axi_bvalid  = ~rst & m_axi_bvalid & ~b_sel;
    s1_axi_bvalid  = ~rst & m_axi_bvalid & b_sel;
    m_axi_bready   = ~rst & (b_sel ? s1_axi_bready : s0_axi_bready);
  end
  assign m_axi_arid    = {ar_gnt_q, ar_gnt_q ? s1_axi_arid : s0_axi_arid};
  assign m_axi_araddr  = ar_gnt_q ? s1_axi_araddr : s0_axi_araddr;
  assign m_axi_arlen   = ar_gnt_q ? s1_axi_arlen : s0_axi_arlen;
  assign m_axi_arsize  = ar_gnt_q ? s1_axi_arsize : s0_axi_arsize;
  assign m_axi_arburst = ar_gnt_q ? s1_axi_arburst : s0_axi_arburst;
  assign m_axi_arlock  = ar_gnt_q ? s1_axi_arlock : s0_axi_arlock;
  assign m_axi_arcache = ar_gnt_q ? s1_axi_arcache : s0_axi_arcache;
  assign m_axi_arprot  = ar_gnt_q ? s1_axi_arprot : s0_axi_arprot;
  assign m_axi_awid    = {aw_gnt_q, aw_gnt_q ? s1_axi_awid : s0_axi_awid};
  assign m_axi_awaddr  = aw_gnt_q ? s1_axi_awaddr : s0_axi_awaddr;
  assign m_axi_awlen   = aw_gnt_q ? s1_axi_awlen : s0_axi_awlen;
  assign m_axi_awsize  = aw_gnt_q ? s1_axi_awsize : s0_axi_awsize;
  assign m_axi_awburst = aw_gnt_q ? s1_axi_awburst : s0_axi_awburst;
  assign m_axi_awlock  = aw_gnt_q ? s1_axi_awlock : s0_axi_awlock;
  assign m_axi_awcache = aw_gnt_q ? s1_axi_awcache : s0_axi_awcache;
  assign m_axi_awprot  = aw_gnt_q ? s1_axi_awprot : s0_axi_awprot;
  assign m_axi_wdata   = aw_gnt_q ? s1_axi_wdata : s0_axi_wdata;
  assign m_axi_wstrb   = aw_gnt_q ? s1_axi_wstrb : s0_axi_wstrb;
  assign m_axi_wlast   = aw_gnt_q ? s1_axi_wlast : s0_axi_wlast;
  assign s0_axi_rid    = m_axi_rid[ID_WIDTH-1:0];
  assign s1_axi_rid    = m_axi_rid[ID_WIDTH-1:0];
  assign s0_axi_rdata  = m_axi_rdata;
  assign s1_axi_rdata  = m_axi_rdata;
  assign s0_axi_rresp  = m_axi_rresp;
  assign s1_axi_rresp  = m_axi_rresp;
  assign s0_axi_rlast  = m_axi_rlast;
  assign s1_axi_rlast  = m_axi_rlast;
  assign s0_axi_bid    = m_axi_bid[ID_WIDTH-1:0];
  assign s1_axi_bid    = m_axi_bid[ID_WIDTH-1:0];
  assign s0_axi_bresp  = m_axi_bresp;
  assign s1_axi_bresp  = m_axi_bresp;
endmodule

// File: tb/tb_mt_fake_axi_arb.sv
// tb_mt_fake_axi_arb: directed checks of arbitration, burst ownership, R/B routing and reset for mt_fake_axi_arb.
module tb_mt_fake_axi_arb;
  localparam int IW = 4, AW = 32, DW = 32, SW = 4;
  logic clk = 1'b0, rst;
  logic [IW-1:0] s0_awid, s1_awid, s0_arid, s1_arid, s0_bid, s1_bid, s0_rid, s1_rid;
  logic [AW-1:0] s0_awaddr, s1_awaddr, s0_araddr, s1_araddr, m_awaddr, m_araddr;
  logic [7:0] s0_awlen, s1_awlen, s0_arlen, s1_arlen, m_awlen, m_arlen;
  logic [2:0] s0_awsize, s1_awsize, s0_arsize, s1_arsize, m_awsize, m_arsize;
  logic [2:0] s0_awprot, s1_awprot, s0_arprot, s1_arprot, m_awprot, m_arprot;
  logic [1:0] s0_awburst, s1_awburst, s0_arburst, s1_arburst, m_awburst, m_arburst;
  logic [3:0] s0_awcache, s1_awcache, s0_arcache, s1_arcache, m_awcache, m_arcache;
  logic s0_awlock, s1_awlock, s0_arlock, s1_arlock, m_awlock, m_arlock;
  logic s0_awvalid, s1_awvalid, s0_awready, s1_awready, s0_arvalid, s1_arvalid, s0_arready, s1_arready;
  logic [DW-1:0] s0_wdata, s1_wdata, m_wdata, s0_rdata, s1_rdata, m_rdata;
  logic [SW-1:0] s0_wstrb, s1_wstrb, m_wstrb;
  logic s0_wlast, s1_wlast, s0_wvalid, s1_wvalid, s0_wready, s1_wready, m_wlast, m_wvalid, m_wready;
  logic [1:0] s0_bresp, s1_bresp, m_bresp, s0_rresp, s1_rresp, m_rresp;
  logic s0_bvalid, s1_bvalid, s0_bready, s1_bready, m_bvalid, m_bready;
  logic s0_rlast, s1_rlast, s0_rvalid, s1_rvalid, s0_rready, s1_rready, m_rlast, m_rvalid, m_rready;
  logic [IW:0] m_awid, m_arid, m_bid, m_rid;
  logic m_awvalid, m_awready, m_arvalid, m_arready;
  int vectors = 0, miscompares = 0;
  mt_fake_axi_arb #(.ID_WIDTH(IW), .ADDR_WIDTH(AW), .DATA_WIDTH(DW), .STRB_WIDTH(SW)) dut (
    .clk(clk), .rst(rst),
    .s0_axi_awid(s0_awid), .s1_axi_awid(s1_awid), .s0_axi_awaddr(s0_awaddr), .s1_axi_awaddr(s1_awaddr),
    .s0_axi_awlen(s0_awlen), .s1_axi_awlen(s1_awlen), .s0_axi_awsize(s0_awsize), .s1_axi_awsize(s1_awsize),
    .s0_axi_awburst(s0_awburst), .s1_axi_awburst(s1_awburst), .s0_axi_awlock(s0_awlock), .s1_axi_awlock(s1_awlock),
    .s0_axi_awcache(s0_awcache), .s1_axi_awcache(s1_awcache), .s0_axi_awprot(s0_awprot), .s1_axi_awprot(s1_awprot),
    .s0_axi_awvalid(s0_awvalid), .s1_axi_awvalid(s1_awvalid), .s0_axi_awready(s0_awready), .s1_axi_awready(s1_awready),
    .s0_axi_wdata(s0_wdata), .s1_axi_wdata(s1_wdata), .s0_axi_wstrb(s0_wstrb), .s1_axi_wstrb(s1_wstrb),
    .s0_axi_wlast(s0_wlast), .s1_axi_wlast(s1_wlast), .s0_axi_wvalid(s0_wvalid), .s1_axi_wvalid(s1_wvalid),
    .s0_axi_wready(s0_wready), .s1_axi_wready(s1_wready),
    .s0_axi_bid(s0_bid), .s1_axi_bid(s1_bid), .s0_axi_bresp(s0_bresp), .s1_axi_bresp(s1_bresp),
    .s0_axi_bvalid(s0_bvalid), .s1_axi_bvalid(s1_bvalid), .s0_axi_bready(s0_bready), .s1_axi_bready(s1_bready),
    .s0_axi_arid(s0_arid), .s1_axi_arid(s1_arid), .s0_axi_araddr(s0_araddr), .s1_axi_araddr(s1_araddr),
    .s0_axi_arlen(s0_arlen), .s1_axi_arlen(s1_arlen), .s0_axi_arsize(s0_arsize), .s1_axi_arsize(s1_arsize),
    .s0_axi_arburst(s0_arburst), .s1_axi_arburst(s1_arburst), .s0_axi_arlock(s0_arlock), .s1_axi_arlock(s1_arlock),
    .s0_axi_arcache(s0_arcache), .s1_axi_arcache(s1_arcache), .s0_axi_arprot(s0_arprot), .s1_axi_arprot(s1_arprot),
    .s0_axi_arvalid(s0_arvalid), .s1_axi_arvalid(s1_arvalid), .s0_axi_arready(s0_arready), .s1_axi_arready(s1_arready),
    .s0_axi_rid(s0_rid), .s1_axi_rid(s1_rid), .s0_axi_rdata(s0_rdata), .s1_axi_rdata(s1_rdata),
    .s0_axi_rresp(s0_rresp), .s1_axi_rresp(s1_rresp), .s0_axi_rlast(s0_rlast), .s1_axi_rlast(s1_rlast),
    .s0_axi_rvalid(s0_rvalid), .s1_axi_rvalid(s1_rvalid), .s0_axi_rready(s0_rready), .s1_axi_rready(s1_rready),
    .m_axi_awid(m_awid), .m_axi_awaddr(m_awaddr), .m_axi_awlen(m_awlen), .m_axi_awsize(m_awsize),
    .m_axi_awburst(m_awburst), .m_axi_awlock(m_awlock), .m_axi_awcache(m_awcache), .m_axi_awprot(m_awprot),
    .m_axi_awvalid(m_awvalid), .m_axi_awready(m_awready),
    .m_axi_wdata(m_wdata), .m_axi_wstrb(m_wstrb), .m_axi_wlast(m_wlast), .m_axi_wvalid(m_wvalid), .m_axi_wready(m_wready),
    .m_axi_bid(m_bid), .m_axi_bresp(m_bresp), .m_axi_bvalid(m_bvalid), .m_axi_bready(m_bready),
    .m_axi_arid(m_arid), .m_axi_araddr(m_araddr), .m_axi_arlen(m_arlen), .m_axi_arsize(m_arsize),
    .m_axi_arburst(m_arburst), .m_axi_arlock(m_arlock), .m_axi_arcache(m_arcache), .m_axi_arprot(m_arprot),
    .m_axi_arvalid(m_arvalid), .m_axi_arready(m_arready),
    .m_axi_rid(m_rid), .m_axi_rdata(m_rdata), .m_axi_rresp(m_rresp), .m_axi_rlast(m_rlast),
    .m_axi_rvalid(m_rvalid), .m_axi_rready(m_rready)
  );
  always #5 clk = ~clk;
  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    vectors++;
    assert (obs === exp) else begin
      miscompares++;
      $display("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
      $error("miscompare at %s", tag);
    end
  endtask
  task automatic step();
    @(posedge clk);
    #1;
  endtask
  initial begin
    rst = 1'b1;
    {s0_awid, s1_awid, s0_arid, s1_arid, s0_awaddr, s1_awaddr, s0_araddr, s1_araddr} = '0;
    {s0_awlen, s1_awlen, s0_arlen, s1_arlen, s0_awsize, s1_awsize, s0_arsize, s1_arsize} = '0;
    {s0_awprot, s1_awprot, s0_arprot, s1_arprot, s0_awburst, s1_awburst, s0_arburst, s1_arburst} = '0;
    {s0_awcache, s1_awcache, s0_arcache, s1_arcache, s0_awlock, s1_awlock, s0_arlock, s1_arlock} = '0;
    {s0_awvalid, s1_awvalid, s1_arvalid, s0_wdata, s1_wdata, s0_wstrb, s1_wstrb} = '0;
    {s0_wlast, s1_wlast, s0_wvalid, s1_wvalid, s1_bready, s1_rready} = '0;
    {m_bid, m_bresp, m_rdata, m_rresp, m_rlast} = '0;
    s0_arvalid = 1'b1; m_rvalid = 1'b1; m_rid = 5'h03; s0_rready = 1'b1;
    m_bvalid = 1'b1; s0_bready = 1'b1;
    m_arready = 1'b1; m_awready = 1'b1; m_wready = 1'b1;
    #1;
    step();
    chk("rst_m_arvalid", 64'(m_arvalid), 0);
    chk("rst_s0_arready", 64'(s0_arready), 0);
    chk("rst_s0_rvalid", 64'(s0_rvalid), 0);
    chk("rst_m_rready", 64'(m_rready), 0);
    chk("rst_s0_bvalid", 64'(s0_bvalid), 0);
    chk("rst_m_bready", 64'(m_bready), 0);
    chk("rst_m_awvalid", 64'(m_awvalid), 0);
    chk("rst_m_wvalid", 64'(m_wvalid), 0);
    rst = 1'b0; m_rvalid = 1'b0; m_bvalid = 1'b0;
    s0_arvalid = 1'b1; s1_arvalid = 1'b1; s0_arid = 4'h3; s1_arid = 4'h5;
    s0_araddr = 32'h100; s1_araddr = 32'h200;
    #1;
    chk("ar_idle_valid", 64'(m_arvalid), 0);
    step();
    chk("ar_g0_valid", 64'(m_arvalid), 1);
    chk("ar_g0_id", 64'(m_arid), 64'h03);
    chk("ar_g0_addr", 64'(m_araddr), 64'h100);
    chk("ar_g0_s0rdy", 64'(s0_arready), 1);
    chk("ar_g0_s1rdy", 64'(s1_arready), 0);
    step();
    s0_arvalid = 1'b0;
    #1;
    chk("ar_back_idle", 64'(m_arvalid), 0);
    step();
    chk("ar_g1_id", 64'(m_arid), 64'h15);
    chk("ar_g1_addr", 64'(m_araddr), 64'h200);
    chk("ar_g1_s1rdy", 64'(s1_arready), 1);
    chk("ar_g1_s0rdy", 64'(s0_arready), 0);
    step();
    s1_arvalid = 1'b0;
    m_rvalid = 1'b1; m_rid = 5'h15; m_rdata = 32'hAB; m_rlast = 1'b1; s0_rready = 1'b1; s1_rready = 1'b1;
    #1;
    chk("r1_s1_rvalid", 64'(s1_rvalid), 1);
    chk("r1_s0_rvalid", 64'(s0_rvalid), 0);
    chk("r1_s1_rid", 64'(s1_rid), 5);
    chk("r1_s1_rdata", 64'(s1_rdata), 64'hAB);
    chk("r1_m_rready", 64'(m_rready), 1);
    m_rid = 5'h03;
    #1;
    chk("r0_s0_rvalid", 64'(s0_rvalid), 1);
    chk("r0_s1_rvalid", 64'(s1_rvalid), 0);
    chk("r0_s0_rid", 64'(s0_rid), 3);
    m_rid = 5'h15; s1_rready = 1'b0;
    #1;
    chk("rstall_m_rready", 64'(m_rready), 0);
    chk("rstall_s0_rvalid", 64'(s0_rvalid), 0);
    chk("rstall_s1_rvalid", 64'(s1_rvalid), 1);
    step();
    s1_rready = 1'b1;
    #1;
    chk("rrise_m_rready", 64'(m_rready), 1);
    m_rvalid = 1'b0;
    s0_arvalid = 1'b1; s1_arvalid = 1'b1;
    step();
    chk("rr_first_id", 64'(m_arid), 64'h03);
    step();
    step();
    chk("rr_second_id", 64'(m_arid), 64'h15);
    chk("rr_second_s0rdy", 64'(s0_arready), 0);
    step();
    s0_arvalid = 1'b0; s1_arvalid = 1'b0;
    s1_awvalid = 1'b1; s1_awid = 4'h6; s1_awlen = 8'd3; s1_awaddr = 32'h300;
    step();
    chk("aw_g1_valid", 64'(m_awvalid), 1);
    chk("aw_g1_id", 64'(m_awid), 64'h16);
    chk("aw_g1_len", 64'(m_awlen), 3);
    chk("aw_g1_s1rdy", 64'(s1_awready), 1);
    s0_awvalid = 1'b1; s0_awid = 4'h2; s0_awlen = 8'd0;
    #1;
    chk("aw_g1_s0rdy", 64'(s0_awready), 0);
    step();
    s1_awvalid = 1'b0; s0_wvalid = 1'b1; s0_wdata = 32'hEE; s0_wlast = 1'b1;
    #1;
    chk("aw_done_valid", 64'(m_awvalid), 0);
    chk("w_stall_valid", 64'(m_wvalid), 0);
    chk("w_stall_s0rdy", 64'(s0_wready), 0);
    for (int i = 1; i <= 4; i++) begin
      s1_wvalid = 1'b1; s1_wdata = 32'(i); s1_wlast = (i == 4);
      #1;
      chk("w_beat_data", 64'(m_wdata), 64'(i));
      chk("w_beat_valid", 64'(m_wvalid), 1);
      chk("w_beat_s1rdy", 64'(s1_wready), 1);
      chk("w_beat_s0rdy", 64'(s0_wready), 0);
      chk("w_beat_s0awrdy", 64'(s0_awready), 0);
      step();
    end
    s1_wvalid = 1'b0; s1_wlast = 1'b0;
    #1;
    chk("aw_idle_after_burst", 64'(m_awvalid), 0);
    chk("w_idle_after_burst", 64'(m_wvalid), 0);
    step();
    chk("aw_g0_id", 64'(m_awid), 64'h02);
    chk("aw_g0_s0rdy", 64'(s0_awready), 1);
    chk("aw_g0_wdata", 64'(m_wdata), 64'hEE);
    step();
    s0_awvalid = 1'b0; s0_wvalid = 1'b0; s0_wlast = 1'b0;
    #1;
    chk("aw_g0_done", 64'(m_awvalid), 0);
    s0_wvalid = 1'b1; s0_wlast = 1'b1; s0_wdata = 32'h55;
    #1;
    chk("wearly_valid1", 64'(m_wvalid), 0);
    chk("wearly_rdy1", 64'(s0_wready), 0);
    step();
    chk("wearly_valid2", 64'(m_wvalid), 0);
    step();
    s0_awvalid = 1'b1; s0_awid = 4'h1;
    #1;
    chk("wearly_aw_idle", 64'(m_awvalid), 0);
    step();
    chk("wearly_awvalid", 64'(m_awvalid), 1);
    chk("wearly_wvalid", 64'(m_wvalid), 1);
    chk("wearly_wdata", 64'(m_wdata), 64'h55);
    chk("wearly_awrdy", 64'(s0_awready), 1);
    chk("wearly_wrdy", 64'(s0_wready), 1);
    step();
    chk("wearly_idle_aw", 64'(m_awvalid), 0);
    chk("wearly_idle_rdy", 64'(s0_awready), 0);
    s0_awvalid = 1'b0; s0_wvalid = 1'b0; s0_wlast = 1'b0;
    step();
    m_bvalid = 1'b1; m_bid = 5'h01; s0_bready = 1'b1; s1_bready = 1'b0;
    #1;
    chk("b0_s0_bvalid", 64'(s0_bvalid), 1);
    chk("b0_s1_bvalid", 64'(s1_bvalid), 0);
    chk("b0_s0_bid", 64'(s0_bid), 1);
    chk("b0_m_bready", 64'(m_bready), 1);
    m_bid = 5'h17; s1_bready = 1'b1; s0_bready = 1'b0;
    #1;
    chk("b1_s1_bvalid", 64'(s1_bvalid), 1);
    chk("b1_s0_bvalid", 64'(s0_bvalid), 0);
    chk("b1_s1_bid", 64'(s1_bid), 7);
    chk("b1_m_bready", 64'(m_bready), 1);
    m_bvalid = 1'b0;
    s0_awvalid = 1'b1; s0_awlen = 8'd7; s0_awid = 4'h4;
    step();
    step();
    s0_awvalid = 1'b0; s0_wvalid = 1'b1; s0_wdata = 32'h1; s0_wlast = 1'b0;
    #1;
    chk("long_beat1", 64'(m_wvalid), 1);
    step();
    s0_wdata = 32'h2; rst = 1'b1;
    #1;
    chk("midrst_wvalid", 64'(m_wvalid), 0);
    chk("midrst_wrdy", 64'(s0_wready), 0);
    step();
    rst = 1'b0; s0_wdata = 32'h3; s0_wlast = 1'b1;
    s0_awvalid = 1'b1; s1_awvalid = 1'b1; s1_wvalid = 1'b1; s1_wlast = 1'b1; s1_wdata = 32'h77; s1_awid = 4'h6;
    #1;
    chk("postrst_wvalid", 64'(m_wvalid), 0);
    chk("postrst_awvalid", 64'(m_awvalid), 0);
    step();
    chk("postrst_ptr_id", 64'(m_awid), 64'h04);
    chk("postrst_wdata", 64'(m_wdata), 64'h3);
    step();
    s0_awvalid = 1'b0; s0_wvalid = 1'b0; s0_wlast = 1'b0;
    step();
    chk("postrst_s1_id", 64'(m_awid), 64'h16);
    chk("postrst_s1_wdata", 64'(m_wdata), 64'h77);
    chk("postrst_s1_wrdy", 64'(s1_wready), 1);
    chk("postrst_s1_awrdy", 64'(s1_awready), 1);
    step();
    s1_awvalid = 1'b0; s1_wvalid = 1'b0; s1_wlast = 1'b0;
    #1;
    chk("final_awvalid", 64'(m_awvalid), 0);
    chk("final_wvalid", 64'(m_wvalid), 0);
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end
endmodule

// File: doc/mt_fake_axi_arb.md
MT_FAKE_AXI_ARB -- requirements
Module: mt_fake_axi_arb

Purpose: 2:1 AXI4 arbiter sharing one axi_slave_ram (fake memory) between two noc_axi4_bridge masters in multi-tile verification.

Interface
REQ-001 The block SHALL have parameter ID_WIDTH, default `AXI4_ID_WIDTH, meaning the master-side ID width; the slave-side ID width is ID_WIDTH+1.
REQ-002 The block SHALL have parameter ADDR_WIDTH, default `AXI4_ADDR_WIDTH, meaning the address width.
REQ-003 The block SHALL have parameter DATA_WIDTH, default `AXI4_DATA_WIDTH, meaning the data width; STRB_WIDTH, default `AXI4_STRB_WIDTH, is the strobe width.
REQ-004 The block SHALL have port clk, input, 1 bit: the single clock.
REQ-005 The block SHALL have port rst, input, 1 bit: synchronous active-high reset.
REQ-006 The block SHALL have, for N in {0,1}, ports sN_axi_aw{id,addr,len,size,burst,lock,cache,prot,valid}, input, standard AXI4 widths: the master N write address; sN_axi_awready is an output, 1 bit.
REQ-007 The block SHALL have ports sN_axi_w{data,strb,last,valid}, input, and sN_axi_wready, output: the master N write data.
REQ-008 The block SHALL have ports sN_axi_b{id,resp,valid}, output, and sN_axi_bready, input: the master N write response.
REQ-009 The block SHALL have ports sN_axi_ar{id,addr,len,size,burst,lock,cache,prot,valid}, input, and sN_axi_arready, output: the master N read address.
REQ-010 The block SHALL have ports sN_axi_r{id,data,resp,last,valid}, output, and sN_axi_rready, input: the master N read data.
REQ-011 The block SHALL have m_axi_* ports mirroring REQ-006..010 with opposite directions toward the RAM, with m_axi_awid, m_axi_arid, m_axi_bid and m_axi_rid each ID_WIDTH+1 bits.

Function
REQ-012 The AR path SHALL be an FSM with states AR_IDLE and AR_BUSY(g); in AR_IDLE, when any sN_axi_arvalid=1, it SHALL register grant g and move to AR_BUSY on the next edge.
REQ-013 In AR_BUSY, the block SHALL drive m_axi_ar* = sg_axi_ar* with m_axi_arid={g,sg_axi_arid}, set sg_axi_arready=m_axi_arready, hold the non-granted arready at 0, and return to AR_IDLE on the m_axi_ar handshake (address latency 1 cycle, peak rate 1 per 2 cycles).
REQ-014 The AW path SHALL be an FSM with states AW_IDLE and AW_BUSY(g) plus flags aw_done and w_done; grant is taken as in REQ-012 from the awvalid inputs.
REQ-015 In AW_BUSY, the block SHALL pass AW from master g until the AW handshake (setting aw_done), and W from master g until the beat with wlast=1 handshakes (setting w_done), in either order or in the same cycle.
REQ-016 The AW path SHALL return to AW_IDLE, clearing both flags, in the cycle where both flags are set or become set; no second AW is granted before then, so W bursts never interleave.
REQ-017 The non-owner's wready and awready SHALL be 0; m_axi_wvalid SHALL be 0 outside AW_BUSY and after w_done; m_axi_awvalid SHALL be 0 after aw_done.
REQ-018 Arbitration SHALL be round robin per channel: on simultaneous requests the master selected by that channel's pointer wins; the pointer moves to the other master after each grant; the AR and AW pointers are independent.
REQ-019 R and B SHALL be demultiplexed by the ID MSB: sN_axi_rvalid = m_axi_rvalid & (rid[MSB]==N), m_axi_rready = rready of the selected master, and sN_axi_rid = the low ID_WIDTH bits; B is handled identically.
REQ-020 The AR and AW paths SHALL operate concurrently with no mutual dependency.
REQ-021 A burst with len=0 (single beat with wlast) SHALL complete normally.

Reset
REQ-022 While rst=1, the block SHALL force both FSMs to IDLE, clear the flags, set both pointers to master 0, and drive all valid and ready outputs to 0.
REQ-023 A reset asserted mid-burst SHALL abandon the burst with no further m_axi beats, and the block SHALL be fully operational in the cycle after deassertion.

Configuration
REQ-024 When MT_FAKE_AXI_ARB_FIXED_PRIO_EN is defined, master 0 SHALL always win simultaneous requests on both channels and the pointers SHALL be removed; when it is undefined, round robin per REQ-018 SHALL apply.

Verification
REQ-025 Both masters assert arvalid in the same cycle after reset -> m_axi_arid MSB is 0 for the first grant and 1 for the second; each master receives only its own R beats with its original IDs.
REQ-026 Master 1 sends AW len=3 with W beats stalled; master 0 sends AW -> master 0 is not granted until master 1's 4th beat with wlast handshakes; no W interleave on m_axi.
REQ-027 W with wlast (len=0) is presented two cycles before its AW -> the transaction completes and the FSM returns to AW_IDLE in the AW handshake cycle; B is routed to the owner.
REQ-028 rst is pulsed during beat 2 of a len=7 write -> all valid outputs are 0 the next cycle; a new write from master 1 then completes; the pointer is 0.
REQ-029 With MT_FAKE_AXI_ARB_FIXED_PRIO_EN defined and both masters requesting continuously for 10 grants -> all 10 grants go to master 0.
REQ-030 Master 1 holds rready=0 with an R beat pending for it -> m_axi_rready=0, s0 sees rvalid=0, and the beat is delivered after rready rises.
